// File: rtl/key_press_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_press_encoder: sync + debounce active-low KEYs, deliver press events    |
// | over valid/ack. Optional release events: define KEY_RELEASE_EVT_EN.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module key_press_encoder #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic                enable,
    input  logic                press_ack,
    output logic                press_valid,
    output logic [NUM_KEYS-1:0] press_onehot,
    output logic [1:0]          press_index,
    output logic                multi_press,
    output logic                overrun,
    output logic                press_release,
    output logic [NUM_KEYS-1:0] keys_level
);

    localparam logic [0:0]       S_IDLE    = 1'b0;
    localparam logic [0:0]       S_PENDING = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [NUM_KEYS-1:0] w_sync_lvl, w_upd, w_rise;
    logic [NUM_KEYS-1:0] w_evt_vec;
    logic                w_evt_multi, w_evt_rel;

    logic [NUM_KEYS-1:0] edge_q;
    logic                edge_multi_q, edge_rel_q;

    logic [0:0]          state_q, state_d;
    logic [NUM_KEYS-1:0] onehot_q, onehot_d;
    logic [1:0]          index_q, index_d;
    logic                multi_q, multi_d;
    logic                rel_q, rel_d;
    logic                overrun_q, overrun_d;
    logic                w_event, w_load, w_clear;

    function automatic logic f_many(input logic [NUM_KEYS-1:0] v);
        return |(v & (v - NUM_KEYS'(1)));
    endfunction

    function automatic logic [1:0] f_lowest(input logic [NUM_KEYS-1:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Synchronizer idles at "released" so a key held through reset still yields an event.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    assign w_sync_lvl = ~sync2_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             w_diff;

        assign w_diff   = w_sync_lvl[k] != stable_q[k];
        assign w_upd[k] = w_diff && (cnt_q == CNT_LAST);

        always_comb begin
            cnt_d = '0;
            if (w_diff && (cnt_q != CNT_LAST)) cnt_d = cnt_q + CNT_W'(1);
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) cnt_q <= '0;
            else         cnt_q <= cnt_d;
        end
    end

    assign stable_d = (stable_q & ~w_upd) | (w_sync_lvl & w_upd);
    assign w_rise   = stable_d & ~stable_q;

`ifdef KEY_RELEASE_EVT_EN
    logic [NUM_KEYS-1:0] w_fall;
    assign w_fall = stable_q & ~stable_d;

    // A press in the same cycle as a release wins; the release is not reported.
    always_comb begin
        w_evt_rel   = ~|w_rise && |w_fall;
        w_evt_vec   = w_evt_rel ? w_fall : w_rise;
        w_evt_multi = w_evt_rel ? f_many(w_fall) : (f_many(w_rise) || |stable_q);
    end
`else
    always_comb begin
        w_evt_rel   = 1'b0;
        w_evt_vec   = w_rise;
        w_evt_multi = f_many(w_rise) || |stable_q;
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stable_q     <= '0;
            edge_q       <= '0;
            edge_multi_q <= 1'b0;
            edge_rel_q   <= 1'b0;
        end else begin
            stable_q     <= stable_d;
            edge_q       <= w_evt_vec;
            edge_multi_q <= w_evt_multi;
            edge_rel_q   <= w_evt_rel;
        end
    end

    assign w_event = |edge_q;

    always_comb begin
        state_d   = state_q;
        onehot_d  = onehot_q;
        index_d   = index_q;
        multi_d   = multi_q;
        rel_d     = rel_q;
        overrun_d = overrun_q;
        w_load    = 1'b0;
        w_clear   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && w_event) begin
                    w_load  = 1'b1;
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (!enable) begin
                    w_clear = 1'b1;
                    state_d = S_IDLE;
                end else if (press_ack) begin
                    overrun_d = 1'b0;
                    if (w_event) begin
                        w_load = 1'b1;
                    end else begin
                        w_clear = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (w_event) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                w_clear = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        if (w_load) begin
            onehot_d = edge_q;
            index_d  = f_lowest(edge_q);
            multi_d  = edge_multi_q;
            rel_d    = edge_rel_q;
        end
        if (w_clear) begin
            onehot_d = '0;
            index_d  = '0;
            multi_d  = 1'b0;
            rel_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            onehot_q  <= '0;
            index_q   <= '0;
            multi_q   <= 1'b0;
            rel_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            onehot_q  <= onehot_d;
            index_q   <= index_d;
            multi_q   <= multi_d;
            rel_q     <= rel_d;
            overrun_q <= overrun_d;
        end
    end

    assign press_valid   = (state_q == S_PENDING);
    assign press_onehot  = onehot_q;
    assign press_index   = index_q;
    assign multi_press   = multi_q;
    assign press_release = rel_q;
    assign overrun       = overrun_q;
    assign keys_level    = stable_q;

endmodule
`default_nettype wire

// File: tb/tb_key_press_encoder.sv
`default_nettype none
// tb_key_press_encoder: directed + randomized bench with an event scoreboard
// fed by a key-level reference model and drained by an output monitor.
module tb_key_press_encoder;

    typedef struct packed {
        logic [3:0] onehot;
        logic [1:0] idx;
        logic       multi;
    } evt_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic [3:0] key_n;
    logic       enable;
    logic       press_ack;
    logic       ack_mon = 1'b0;
    logic       ack_stim = 1'b0;
    logic       auto_ack = 1'b0;
    logic       press_valid;
    logic [3:0] press_onehot;
    logic [1:0] press_index;
    logic       multi_press;
    logic       overrun;
    logic       press_release;
    logic [3:0] keys_level;

    evt_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    assign press_ack = ack_mon | ack_stim;

    key_press_encoder #(
        .NUM_KEYS       (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .key_n        (key_n),
        .enable       (enable),
        .press_ack    (press_ack),
        .press_valid  (press_valid),
        .press_onehot (press_onehot),
        .press_index  (press_index),
        .multi_press  (multi_press),
        .overrun      (overrun),
        .press_release(press_release),
        .keys_level   (keys_level)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: a press event reports the keys that became pressed between two
    // settled key patterns; it is multi if several keys went down or any key was already down.
    function automatic void model_event(input logic [3:0] old_p, input logic [3:0] new_p);
        logic [3:0] newly;
        evt_t       e;
        int         n;
        newly = new_p & ~old_p;
        if (newly == 4'b0000) return;
        n     = 0;
        e.idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (newly[i]) begin
                e.idx = 2'(i);
                n++;
            end
        end
        e.onehot = newly;
        e.multi  = (n > 1) || (old_p != 4'b0000);
        exp_q.push_back(e);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 30) begin
            @(posedge clock);
            #1;
            lat++;
            if (press_valid) break;
        end
    endtask

    task automatic pulse_ack();
        ack_stim = 1'b1;
        step(1);
        ack_stim = 1'b0;
    endtask

    initial begin : monitor
        evt_t e;
        logic taken;
        taken = 1'b0;
        forever begin
            @(negedge clock);
            ack_mon = 1'b0;
            if (resetn !== 1'b1) begin
                taken = 1'b0;
            end else if (press_valid && !taken) begin
                taken = 1'b1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: got onehot %b expected none", press_onehot);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_onehot", {28'd0, press_onehot}, {28'd0, e.onehot});
                    chk("evt_index", {30'd0, press_index}, {30'd0, e.idx});
                    chk("evt_multi", {31'd0, multi_press}, {31'd0, e.multi});
                end
                chk("evt_release", {31'd0, press_release}, 32'd0);
                if (auto_ack) ack_mon = 1'b1;
            end else if (!press_valid) begin
                taken = 1'b0;
                chk("idle_zero", {25'd0, press_onehot, press_index, multi_press}, 32'd0);
            end
        end
    end

    initial begin : watchdog
        #60000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int         lat;
        logic       seen;
        logic [3:0] prev, nxt;

        key_n  = 4'b1111;
        enable = 1'b1;
        resetn = 1'b0;
        step(3);
        chk("reset_outputs", {20'd0, press_valid, press_onehot, press_index, multi_press,
                              overrun, keys_level[0]}, 32'd0);
        chk("reset_levels", {28'd0, keys_level}, 32'd0);
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (press_valid || overrun) seen = 1'b1;
        end
        chk("reset_quiet", {31'd0, seen}, 32'd0);

        // Clean press of KEY1
        model_event(4'b0000, 4'b0010);
        key_n = 4'b1101;
        wait_valid(lat);
        chk("clean_latency", lat, 7);
        chk("clean_level", {28'd0, keys_level}, 32'h2);
        step(4);
        chk("clean_hold", {24'd0, press_valid, press_onehot, press_index, multi_press},
            {24'd0, 1'b1, 4'b0010, 2'd1, 1'b0});
        pulse_ack();
        chk("clean_ack", {31'd0, press_valid}, 32'd0);
        key_n = 4'b1111;
        step(12);

        // Bouncing KEY0
        model_event(4'b0000, 4'b0001);
        for (int i = 0; i < 6; i++) begin
            key_n[0] = 1'(i % 2);
            step(2);
        end
        key_n[0] = 1'b0;
        wait_valid(lat);
        chk("bounce_latency", lat, 7);
        chk("bounce_onehot", {28'd0, press_onehot}, 32'h1);
        pulse_ack();
        key_n = 4'b1111;
        step(12);

        // Simultaneous KEY0 + KEY2
        model_event(4'b0000, 4'b0101);
        key_n = 4'b1010;
        wait_valid(lat);
        chk("simul", {25'd0, press_onehot, press_index, multi_press}, {25'd0, 4'b0101, 2'd0, 1'b1});
        pulse_ack();
        key_n = 4'b1111;
        step(12);

        // Overrun: KEY3 pending, KEY1 dropped
        model_event(4'b0000, 4'b1000);
        key_n = 4'b0111;
        wait_valid(lat);
        key_n = 4'b0101;
        step(12);
        chk("ovr_hold", {26'd0, press_valid, press_onehot, overrun}, {26'd0, 1'b1, 4'b1000, 1'b1});
        pulse_ack();
        chk("ovr_ack", {30'd0, press_valid, overrun}, 32'd0);
        key_n = 4'b1111;
        step(12);

        // Enable drop while pending, then presses while disabled
        model_event(4'b0000, 4'b0100);
        key_n = 4'b1011;
        wait_valid(lat);
        chk("en_pending", {31'd0, press_valid}, 32'd1);
        enable = 1'b0;
        step(1);
        chk("en_drop", {27'd0, press_valid, press_onehot}, 32'd0);
        key_n = 4'b1010;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (press_valid) seen = 1'b1;
        end
        chk("en_discard", {31'd0, seen}, 32'd0);
        key_n = 4'b1111;
        step(12);
        enable = 1'b1;
        step(2);

        // Randomized settled patterns, with and without bounce
        auto_ack = 1'b1;
        prev     = 4'b0000;
        for (int t = 0; t < 24; t++) begin
            nxt = 4'($urandom_range(0, 15));
            model_event(prev, nxt);
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 2; b++) begin
                    key_n = ~nxt;
                    step(2);
                    key_n = ~prev;
                    step(2);
                end
            end
            key_n = ~nxt;
            step(14);
            chk("rnd_level", {28'd0, keys_level}, {28'd0, nxt});
            prev = nxt;
        end
        step(5);

        chk("queue_empty", exp_q.size(), 0);
        chk("final_overrun", {31'd0, overrun}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
